mmio_axil_master: RTL and testbench

MMIO_AXIL_MASTER -- requirements
Module: mmio_axil_master

---
 rtl/mmio_axil_master.sv | 229 ++++++++++++++++++++++
 tb/tb_mmio_axil_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_axil_master.sv
// ---------------------------------------------------------------------------------------------
// mmio_axil_master
//
// Bridges a simple CPU MMIO request/response handshake onto an AXI4-Lite master port. Only one
// transaction is in flight at a time. A request is accepted in IDLE, turned into either an
// AW+W / B exchange or an AR / R exchange, and the result is presented on the response port
// until the CPU takes it.
//
// Ports
//   clock, async_resetn        sole clock (rising edge); asynchronous active-low reset
//   req_valid/req_ready        CPU request handshake; req_we selects write (1) or read (0)
//   req_addr, req_wdata        byte address and write data, passed through unmodified
//   resp_valid/resp_ready      CPU response handshake
//   resp_rdata, resp_err       read data (0 for writes); 1 when BRESP/RRESP is non-zero
//   m_axi_aw*, m_axi_w*        AXI-Lite write address / write data channels
//   m_axi_b*                   AXI-Lite write response channel
//   m_axi_ar*, m_axi_r*        AXI-Lite read address / read data channels
// ---------------------------------------------------------------------------------------------
module mmio_axil_master #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  async_resetn,

    // CPU request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    // CPU response
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    // AXI-Lite AW
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // AXI-Lite W
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // AXI-Lite B
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    // AXI-Lite AR
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI-Lite R
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StResp
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Reset synchroniser: assertion is asynchronous, release is delayed by two clock edges so
    // every flop below leaves reset on the same edge.
    // -----------------------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e                  state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
    logic                    awvalid_q,    awvalid_d;
    logic                    wvalid_q,     wvalid_d;
    logic                    arvalid_q,    arvalid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q,   resp_err_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    logic aw_done;
    logic w_done;

    // A channel counts as done once its VALID has been dropped or it handshakes this cycle;
    // this lets AW and W finish in either order or together.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrReq;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRdReq;
                    end
                end
            end

            StWrReq: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d = StWrResp;
                end
            end

            StWrResp: begin
                if (m_axi_bvalid) begin
                    resp_err_d   = (m_axi_bresp != 2'b00);
                    resp_rdata_d = '0;
                    state_d      = StResp;
                end
            end

            StRdReq: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdResp;
                end
            end

            StRdResp: begin
                if (m_axi_rvalid) begin
                    resp_rdata_d = m_axi_rdata;
                    resp_err_d   = (m_axi_rresp != 2'b00);
                    state_d      = StResp;
                end
            end

            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    // Gated by rst_n so req_ready stays low for the whole reset, including the sync window.
    assign req_ready     = rst_n && (state_q == StIdle);

    assign resp_valid    = (state_q == StResp);
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == StWrResp);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == StRdResp);

endmodule

// File: tb/tb_mmio_axil_master.sv
// ---------------------------------------------------------------------------------------------
// tb_mmio_axil_master
//
// Directed bench for mmio_axil_master. The AXI-Lite slave side is driven by hand from each
// scenario task. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------------------------
module tb_mmio_axil_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clock;
    logic          async_resetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    int checks = 0;
    int errors = 0;

    // {awvalid, wvalid, bready, arvalid, rready}
    logic [4:0] axi_ctl;
    assign axi_ctl = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};

    mmio_axil_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock         (clock),
        .async_resetn  (async_resetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (axi_ctl !== 5'b00000) begin
            errors++; $display("FAIL reset_axi_ctl: got %b want %b", axi_ctl, 5'b00000);
        end
        checks++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {req_ready, resp_valid, resp_err});
        end
        checks++;
        if (resp_rdata !== 32'h0 || m_axi_awaddr !== 16'h0 || m_axi_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0",
                               resp_rdata, m_axi_awaddr, m_axi_wdata);
        end
        async_resetn = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_sync_hold: req_ready got %b want 0", req_ready);
        end
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: req_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0004; req_wdata = 32'h0000_0041;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (axi_ctl !== 5'b11000 || m_axi_awaddr !== 16'h0004 || m_axi_wdata !== 32'h41) begin
            errors++; $display("FAIL wr_cycle1: got ctl=%b addr=%h wdata=%h want 11000/0004/41",
                               axi_ctl, m_axi_awaddr, m_axi_wdata);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL wr_busy: req_ready got %b want 0", req_ready);
        end
        @(negedge clock);
        checks++;
        if (axi_ctl !== 5'b00100) begin
            errors++; $display("FAIL wr_cycle2: ctl got %b want 00100", axi_ctl);
        end
        @(negedge clock);
        checks++;
        if (axi_ctl !== 5'b00000 || resp_valid !== 1'b1 || resp_err !== 1'b0 ||
            resp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_cycle3: got ctl=%b rv=%b err=%b rdata=%h want 00000/1/0/0",
                               axi_ctl, resp_valid, resp_err, resp_rdata);
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_done: got rv=%b rr=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_read();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0008;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h05; m_axi_rresp = 2'b00;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (axi_ctl !== 5'b00010 || m_axi_araddr !== 16'h0008) begin
            errors++; $display("FAIL rd_cycle1: got ctl=%b addr=%h want 00010/0008",
                               axi_ctl, m_axi_araddr);
        end
        @(negedge clock);
        checks++;
        if (axi_ctl !== 5'b00001) begin
            errors++; $display("FAIL rd_cycle2: ctl got %b want 00001", axi_ctl);
        end
        @(negedge clock);
        checks++;
        if (axi_ctl !== 5'b00000 || resp_valid !== 1'b1 || resp_rdata !== 32'h05 ||
            resp_err !== 1'b0) begin
            errors++; $display("FAIL rd_resp: got ctl=%b rv=%b rdata=%h err=%b want 00000/1/05/0",
                               axi_ctl, resp_valid, resp_rdata, resp_err);
        end
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_done: got rv=%b rr=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_errors();
        // Write with SLVERR; previous read left 0x05 in resp_rdata, which must be cleared.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 32'h1111_2222;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL err_bresp: got rv=%b err=%b rdata=%h want 1/1/0",
                               resp_valid, resp_err, resp_rdata);
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        // Read with DECERR.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0200;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF;
        m_axi_rresp = 2'b11;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL err_rresp: got rv=%b err=%b rdata=%h want 1/1/deadbeef",
                               resp_valid, resp_err, resp_rdata);
        end
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_wready_delay();
        int b_count = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 32'hCAFE_0001;
        m_axi_awready = 1'b1; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (axi_ctl !== 5'b11000) begin
            errors++; $display("FAIL wd_start: ctl got %b want 11000", axi_ctl);
        end
        // AW handshakes on this edge, W is held off for four cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            m_axi_awready = 1'b0;
            checks++;
            if (axi_ctl !== 5'b01000 || m_axi_wdata !== 32'hCAFE_0001) begin
                errors++; $display("FAIL wd_hold[%0d]: got ctl=%b wdata=%h want 01000/cafe0001",
                                   i, axi_ctl, m_axi_wdata);
            end
        end
        m_axi_wready = 1'b1;
        @(negedge clock);
        m_axi_wready = 1'b0;
        checks++;
        if (axi_ctl !== 5'b00100) begin
            errors++; $display("FAIL wd_wdone: ctl got %b want 00100", axi_ctl);
        end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (m_axi_bready && m_axi_bvalid) b_count++;
            @(negedge clock);
        end
        checks++;
        if (b_count !== 1 || resp_valid !== 1'b1 || resp_err !== 1'b0) begin
            errors++; $display("FAIL wd_bcount: got beats=%0d rv=%b err=%b want 1/1/0",
                               b_count, resp_valid, resp_err);
        end
        m_axi_bvalid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_resp_stall();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678;
        m_axi_rresp = 2'b00;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0;
        // A new write is already pending while the CPU stalls the response.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 32'h0000_0077;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0 ||
                req_ready !== 1'b0 || axi_ctl !== 5'b00000) begin
                errors++; $display("FAIL stall[%0d]: got rv=%b rdata=%h err=%b rr=%b ctl=%b",
                                   i, resp_valid, resp_rdata, resp_err, req_ready, axi_ctl);
            end
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || axi_ctl !== 5'b00000) begin
            errors++; $display("FAIL stall_release: got rv=%b rr=%b ctl=%b want 0/1/00000",
                               resp_valid, req_ready, axi_ctl);
        end
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (axi_ctl !== 5'b11000 || m_axi_awaddr !== 16'h0020 || m_axi_wdata !== 32'h77) begin
            errors++; $display("FAIL stall_next: got ctl=%b addr=%h wdata=%h want 11000/0020/77",
                               axi_ctl, m_axi_awaddr, m_axi_wdata);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL stall_next_resp: got rv=%b rdata=%h want 1/0",
                               resp_valid, resp_rdata);
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0030; req_wdata = 32'h0000_0099;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        checks++;
        if (axi_ctl !== 5'b00100) begin
            errors++; $display("FAIL rm_in_wr_resp: ctl got %b want 00100", axi_ctl);
        end
        // Assert reset between clock edges: outputs must clear without a clock edge.
        #2 async_resetn = 1'b0;
        #1;
        checks++;
        if (axi_ctl !== 5'b00000 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rm_async: got ctl=%b rr=%b rv=%b want 00000/0/0",
                               axi_ctl, req_ready, resp_valid);
        end
        m_axi_bvalid = 1'b1;
        repeat (2) @(negedge clock);
        async_resetn = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rm_sync: got rr=%b rv=%b want 0/0", req_ready, resp_valid);
        end
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || axi_ctl !== 5'b00000) begin
            errors++; $display("FAIL rm_idle: got rr=%b rv=%b ctl=%b want 1/0/00000",
                               req_ready, resp_valid, axi_ctl);
        end
        m_axi_bvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h000C;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_00A5;
        m_axi_rresp = 2'b00;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (axi_ctl !== 5'b00010 || m_axi_araddr !== 16'h000C) begin
            errors++; $display("FAIL rm_read_ar: got ctl=%b addr=%h want 00010/000c",
                               axi_ctl, m_axi_araddr);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5 || resp_err !== 1'b0) begin
            errors++; $display("FAIL rm_read_resp: got rv=%b rdata=%h err=%b want 1/a5/0",
                               resp_valid, resp_rdata, resp_err);
        end
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_read_done: got rv=%b rr=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    initial begin
        async_resetn  = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        resp_ready    = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bvalid  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rvalid  = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_read();
        test_errors();
        test_wready_delay();
        test_resp_stall();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
